job_dispatcher: RTL and testbench
=================================

JOB_DISPATCHER -- requirements
Module: job_dispatcher

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: max cycles waited for eng_done after issue; legal range 1..2^32-1.
REQ-002 Parameter ID_W, default 4: width of command/response tag.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  dispatcher accepts command this cycle.
REQ-007 cmd_n  input  32  target count forwarded to engine.
REQ-008 cmd_id  input  ID_W  command tag.
REQ-009 eng_start  output  1  start level to counter engine.
REQ-010 eng_n  output  32  target count to engine; stable while eng_start high.
REQ-011 eng_done  input  1  engine done level.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  response consumer ready.
REQ-014 rsp_id  output  ID_W  tag of completed command.
REQ-015 rsp_cycles  output  32  measured issue-to-done cycles.
REQ-016 rsp_timeout  output  1  command ended by timeout.
REQ-017 err_sticky  output  1  set on any timeout; cleared only by rst.
REQ-018 state_out  output  2  current state encoding for debug.

Function
REQ-019 States: IDLE=0, ISSUE=1, RELEASE=2, RESP=3; all outputs registered or decoded from registered state only.
REQ-020 cmd_ready SHALL be 1 exactly when state==IDLE; handshake = cmd_valid & cmd_ready on a rising edge.
REQ-021 IDLE: on handshake latch cmd_n into eng_n, cmd_id into rsp_id, clear cycle counter and rsp_timeout, go ISSUE; else stay.
REQ-022 eng_start SHALL be 1 exactly when state==ISSUE.
REQ-023 ISSUE: each edge with eng_done=0 increments cycle counter (saturating at 2^32-1).
REQ-024 ISSUE: edge with eng_done=1 latches counter into rsp_cycles, go RELEASE; done has priority over timeout on the same edge.
REQ-025 ISSUE: edge with eng_done=0 and counter==TIMEOUT_CYCLES sets rsp_timeout=1, err_sticky=1, rsp_cycles=TIMEOUT_CYCLES, go RESP (skips RELEASE).
REQ-026 RELEASE: eng_start=0; stay until an edge samples eng_done=0, then go RESP.
REQ-027 RESP: rsp_valid=1; rsp_id, rsp_cycles, rsp_timeout held stable; on rsp_valid & rsp_ready go IDLE.
REQ-028 No command accepted before the prior response handshake completes; at most one command in flight.
REQ-029 eng_done=1 observed in IDLE or RESP SHALL be ignored (no state change, no error).
REQ-030 cmd_n=0 and cmd_n=2^32-1 SHALL be forwarded unmodified.
REQ-031 Against the team counter engine, a command of N completes with rsp_cycles=N+2.
REQ-032 Back-to-back: a new command may be accepted the cycle after the response handshake (IDLE for >=1 cycle).

Reset
REQ-033 On rst: state=IDLE, cmd_ready=1, eng_start=0, eng_n=0, rsp_valid=0, rsp_id=0, rsp_cycles=0, rsp_timeout=0, err_sticky=0, state_out=0, counter=0.
REQ-034 rst asserted in any state, mid-command included, SHALL take effect immediately and discard the in-flight command without producing a response.
REQ-035 First command accepted no earlier than the first rising edge after rst deasserts.

Verification
REQ-036 Counter-engine model, cmd_n=5, id=3, rsp_ready=1 -> eng_start high 7 cycles, rsp_valid with rsp_id=3, rsp_cycles=7, rsp_timeout=0.
REQ-037 cmd_n=0 -> rsp_cycles=2; eng_n=0 while eng_start high.
REQ-038 TIMEOUT_CYCLES=16, eng_done tied 0 -> eng_start drops after 16 counted cycles, rsp_timeout=1, rsp_cycles=16, err_sticky=1 until rst.
REQ-039 rsp_ready held 0 for 10 cycles -> rsp_valid and fields stable, cmd_ready=0, cmd_valid ignored; completes on rsp_ready=1.
REQ-040 Two commands cmd_valid held continuously (N=3 id=1, N=4 id=2) -> responses in order, rsp_cycles 5 then 6, engine never sees start while done high.
REQ-041 rst pulsed while in ISSUE and while in RESP -> all outputs at REQ-033 values same cycle, no response emitted, next command completes normally.

Source files
------------

// File: rtl/job_dispatcher.sv
// Single-command dispatcher: hands one job at a time to a counter engine,
// measures issue-to-done latency with a timeout, and returns a tagged response.
module job_dispatcher #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ID_W           = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [31:0]     cmd_n,
  input  logic [ID_W-1:0] cmd_id,
  output logic            eng_start,
  output logic [31:0]     eng_n,
  input  logic            eng_done,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [31:0]     rsp_cycles,
  output logic            rsp_timeout,
  output logic            err_sticky,
  output logic [1:0]      state_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] CNT_MAX     = '1;

  state_e          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     eng_n_q, eng_n_d;
  logic [31:0]     cycles_q, cycles_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            timeout_q, timeout_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      eng_n_q   <= '0;
      cycles_q  <= '0;
      id_q      <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      eng_n_q   <= eng_n_d;
      cycles_q  <= cycles_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eng_n_d   = eng_n_q;
    cycles_d  = cycles_q;
    id_d      = id_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        // cmd_ready is 1 throughout IDLE, so cmd_valid alone completes the handshake
        if (cmd_valid) begin
          eng_n_d   = cmd_n;
          id_d      = cmd_id;
          cnt_d     = '0;
          timeout_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // done wins over timeout when both would fire on the same edge
        if (eng_done) begin
          cycles_d = cnt_q;
          state_d  = S_RELEASE;
        end else if (cnt_q == TIMEOUT_LIM) begin
          timeout_d = 1'b1;
          err_d     = 1'b1;
          cycles_d  = TIMEOUT_LIM;
          state_d   = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RELEASE: begin
        if (!eng_done) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign eng_start   = (state_q == S_ISSUE);
  assign rsp_valid   = (state_q == S_RESP);
  assign state_out   = state_q;
  assign eng_n       = eng_n_q;
  assign rsp_id      = id_q;
  assign rsp_cycles  = cycles_q;
  assign rsp_timeout = timeout_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_job_dispatcher.sv
// Directed bench for job_dispatcher against a behavioural counter engine whose
// done rises so that a command of N reports N+2 cycles.
module tb_job_dispatcher;

  localparam int unsigned ID_W = 4;
  localparam int unsigned TO   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [31:0]     cmd_n = '0;
  logic [ID_W-1:0] cmd_id = '0;
  logic            eng_start;
  logic [31:0]     eng_n;
  logic            eng_done;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [ID_W-1:0] rsp_id;
  logic [31:0]     rsp_cycles;
  logic            rsp_timeout;
  logic            err_sticky;
  logic [1:0]      state_out;

  int checks = 0;
  int errors = 0;

  // 0: engine model, 1: done forced low, 2: done forced high
  logic [1:0]  done_mode = 2'd0;
  logic [32:0] eng_cnt;
  logic        eng_done_m;

  localparam logic [74:0] RST_VEC = {1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 2'd0};

  job_dispatcher #(.TIMEOUT_CYCLES(TO), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n), .cmd_id(cmd_id),
    .eng_start(eng_start), .eng_n(eng_n), .eng_done(eng_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout),
    .err_sticky(err_sticky), .state_out(state_out)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_cnt    <= '0;
      eng_done_m <= 1'b0;
    end else if (!eng_start) begin
      eng_cnt    <= '0;
      eng_done_m <= 1'b0;
    end else if (!eng_done_m) begin
      if (eng_cnt == {1'b0, eng_n} + 33'd1) eng_done_m <= 1'b1;
      else eng_cnt <= eng_cnt + 33'd1;
    end
  end

  assign eng_done = (done_mode == 2'd0) ? eng_done_m : (done_mode == 2'd2);

  function automatic logic [74:0] out_vec();
    return {cmd_ready, eng_start, eng_n, rsp_valid, rsp_id, rsp_cycles, rsp_timeout, err_sticky, state_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command with rsp_ready=1 and collects its response.
  task automatic issue_and_wait(input logic [31:0] n, input logic [ID_W-1:0] id,
                                output logic [31:0] cyc, output logic [ID_W-1:0] rid,
                                output logic to, output int starts,
                                output logic eng_n_bad, output logic got);
    cmd_valid = 1'b1; cmd_n = n; cmd_id = id; rsp_ready = 1'b1;
    got = 1'b0; starts = 0; eng_n_bad = 1'b0; cyc = '0; rid = '0; to = 1'b0;
    for (int k = 0; k < 200 && !cmd_ready; k++) tick();
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (rsp_valid) begin
        got = 1'b1; cyc = rsp_cycles; rid = rsp_id; to = rsp_timeout;
        break;
      end
      if (eng_start) begin
        if (!eng_done) starts++;
        if (eng_n !== n) eng_n_bad = 1'b1;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", out_vec(), RST_VEC);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state_out !== 2'd0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: got state %0d ready %0d expected 0 1", state_out, cmd_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] cyc; logic [ID_W-1:0] rid; logic to, bad, got; int starts;
    issue_and_wait(32'd5, 4'd3, cyc, rid, to, starts, bad, got);
    checks++; if (!got) begin errors++; $display("FAIL basic_rsp_seen: got 0 expected 1"); end
    checks++; if (cyc !== 32'd7) begin errors++; $display("FAIL basic_cycles: got %0d expected 7", cyc); end
    checks++; if (rid !== 4'd3) begin errors++; $display("FAIL basic_id: got %0d expected 3", rid); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", to); end
    // start high with done low on 7 edges; the 8th start edge carries done
    checks++; if (starts != 7) begin errors++; $display("FAIL basic_start_edges: got %0d expected 7", starts); end
    checks++; if (bad) begin errors++; $display("FAIL basic_eng_n: got unstable expected 5"); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL basic_err: got %0d expected 0", err_sticky); end
  endtask

  task automatic test_zero();
    logic [31:0] cyc; logic [ID_W-1:0] rid; logic to, bad, got; int starts;
    issue_and_wait(32'd0, 4'hA, cyc, rid, to, starts, bad, got);
    checks++; if (!got) begin errors++; $display("FAIL zero_rsp_seen: got 0 expected 1"); end
    checks++; if (cyc !== 32'd2) begin errors++; $display("FAIL zero_cycles: got %0d expected 2", cyc); end
    checks++; if (bad) begin errors++; $display("FAIL zero_eng_n: got nonzero expected 0"); end
    checks++; if (rid !== 4'hA) begin errors++; $display("FAIL zero_id: got %0d expected 10", rid); end
  endtask

  task automatic test_done_ignored_idle();
    done_mode = 2'd2;
    repeat (3) tick();
    checks++;
    if (state_out !== 2'd0 || err_sticky !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL idle_done_ignored: got state %0d err %0d valid %0d expected 0 0 0",
                          state_out, err_sticky, rsp_valid);
    end
    done_mode = 2'd0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] cyc, snap_cyc; logic [ID_W-1:0] rid, snap_id; logic to, bad, got, snap_to; int starts;
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_n = 32'd2; cmd_id = 4'd5;
    tick();
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (rsp_valid) got = 1'b1; else tick();
    end
    checks++; if (!got) begin errors++; $display("FAIL bp_rsp_seen: got 0 expected 1"); end
    snap_cyc = rsp_cycles; snap_id = rsp_id; snap_to = rsp_timeout;
    checks++;
    if (snap_cyc !== 32'd4 || snap_id !== 4'd5 || snap_to !== 1'b0) begin
      errors++; $display("FAIL bp_fields: got %0d/%0d/%0d expected 4/5/0", snap_cyc, snap_id, snap_to);
    end
    cmd_valid = 1'b1; cmd_n = 32'd1; cmd_id = 4'd7; done_mode = 2'd2;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || state_out !== 2'd3 || cmd_ready !== 1'b0 ||
          rsp_cycles !== snap_cyc || rsp_id !== snap_id || rsp_timeout !== snap_to || err_sticky !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: got valid %0d state %0d ready %0d cyc %0d id %0d expected 1 3 0 4 5",
                           k, rsp_valid, state_out, cmd_ready, rsp_cycles, rsp_id);
      end
    end
    done_mode = 2'd0; rsp_ready = 1'b1;
    tick();
    checks++;
    if (state_out !== 2'd0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got state %0d valid %0d ready %0d expected 0 0 1",
                         state_out, rsp_valid, cmd_ready);
    end
    issue_and_wait(32'd1, 4'd7, cyc, rid, to, starts, bad, got);
    checks++;
    if (!got || cyc !== 32'd3 || rid !== 4'd7) begin
      errors++; $display("FAIL bp_pending_cmd: got seen %0d cyc %0d id %0d expected 1 3 7", got, cyc, rid);
    end
  endtask

  task automatic test_back_to_back();
    int ci = 0, ri = 0, edge_no = 0, rsp1_edge = -1, cmd2_edge = -1, viol = 0;
    logic hs, rh, prev_start = 1'b0;
    logic [31:0] cyc [2];
    logic [ID_W-1:0] ids [2];
    cyc[0] = '0; cyc[1] = '0; ids[0] = '0; ids[1] = '0;
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_n = 32'd3; cmd_id = 4'd1;
    for (int k = 0; k < 200 && ri < 2; k++) begin
      hs = cmd_valid && cmd_ready;
      rh = rsp_valid && rsp_ready;
      if (rh) begin
        cyc[ri] = rsp_cycles; ids[ri] = rsp_id;
        if (ri == 0) rsp1_edge = edge_no + 1;
        ri++;
      end
      if (eng_start && !prev_start && eng_done) viol++;
      prev_start = eng_start;
      tick();
      edge_no++;
      if (hs) begin
        ci++;
        if (ci == 1) begin cmd_n = 32'd4; cmd_id = 4'd2; end
        else begin cmd_valid = 1'b0; cmd2_edge = edge_no; end
      end
    end
    checks++; if (ri != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", ri); end
    checks++;
    if (cyc[0] !== 32'd5 || ids[0] !== 4'd1) begin
      errors++; $display("FAIL b2b_first: got cyc %0d id %0d expected 5 1", cyc[0], ids[0]);
    end
    checks++;
    if (cyc[1] !== 32'd6 || ids[1] !== 4'd2) begin
      errors++; $display("FAIL b2b_second: got cyc %0d id %0d expected 6 2", cyc[1], ids[1]);
    end
    checks++;
    if (cmd2_edge != rsp1_edge + 1) begin
      errors++; $display("FAIL b2b_accept_edge: got %0d expected %0d", cmd2_edge, rsp1_edge + 1);
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL b2b_start_with_done: got %0d expected 0", viol); end
    tick();
  endtask

  task automatic test_reset_midflight();
    logic [31:0] cyc; logic [ID_W-1:0] rid; logic to, bad, got; int starts;
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_n = 32'd10; cmd_id = 4'd4;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (state_out !== 2'd1 || eng_start !== 1'b1) begin
      errors++; $display("FAIL mid_in_issue: got state %0d start %0d expected 1 1", state_out, eng_start);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++; $display("FAIL mid_issue_reset: got %h expected %h", out_vec(), RST_VEC);
    end
    #2 rst = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 4; k++) begin tick(); if (rsp_valid) got = 1'b1; end
    checks++; if (got) begin errors++; $display("FAIL mid_issue_no_rsp: got 1 expected 0"); end

    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_n = 32'd0; cmd_id = 4'd6;
    tick();
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      if (rsp_valid) got = 1'b1; else tick();
    end
    checks++; if (!got) begin errors++; $display("FAIL mid_reach_resp: got 0 expected 1"); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== RST_VEC) begin
      errors++; $display("FAIL mid_resp_reset: got %h expected %h", out_vec(), RST_VEC);
    end
    #2 rst = 1'b0;
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); if (rsp_valid) got = 1'b1; end
    checks++; if (got) begin errors++; $display("FAIL mid_resp_no_rsp: got 1 expected 0"); end
    issue_and_wait(32'd1, 4'd2, cyc, rid, to, starts, bad, got);
    checks++;
    if (!got || cyc !== 32'd3 || rid !== 4'd2 || to !== 1'b0) begin
      errors++; $display("FAIL mid_recover: got seen %0d cyc %0d id %0d to %0d expected 1 3 2 0", got, cyc, rid, to);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] cyc; logic [ID_W-1:0] rid; logic to, bad, got; int starts;
    done_mode = 2'd1;
    issue_and_wait(32'hFFFF_FFFF, 4'd9, cyc, rid, to, starts, bad, got);
    checks++; if (!got) begin errors++; $display("FAIL to_rsp_seen: got 0 expected 1"); end
    checks++; if (bad) begin errors++; $display("FAIL to_eng_n_max: got altered expected ffffffff"); end
    // 16 counting edges plus the edge that detects the limit
    checks++; if (starts != 17) begin errors++; $display("FAIL to_start_edges: got %0d expected 17", starts); end
    checks++; if (cyc !== 32'd16) begin errors++; $display("FAIL to_cycles: got %0d expected 16", cyc); end
    checks++; if (to !== 1'b1) begin errors++; $display("FAIL to_flag: got %0d expected 1", to); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL to_err_set: got %0d expected 1", err_sticky); end
    done_mode = 2'd0;
    issue_and_wait(32'd1, 4'd3, cyc, rid, to, starts, bad, got);
    checks++;
    if (!got || cyc !== 32'd3 || to !== 1'b0) begin
      errors++; $display("FAIL to_next_cmd: got seen %0d cyc %0d to %0d expected 1 3 0", got, cyc, to);
    end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL to_err_held: got %0d expected 1", err_sticky); end
    #2 rst = 1'b1;
    #1;
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL to_err_cleared: got %0d expected 0", err_sticky); end
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_done_ignored_idle();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
